// File: rtl/br_sequencer.sv
// br_sequencer: four-state R-type sequencer that reads operands, executes and writes back.
// It drives an external register file and keeps a wrapping count of retired instructions.
module br_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic [4:0]  DL1,
    output logic [4:0]  DL2,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic        we,
    output logic [4:0]  DE,
    output logic [31:0] Dato,
    output logic        done,
    output logic        err,
    output logic [15:0] retired
);
    typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;
    state_t state_q, state_d;
    logic [5:0] opc_q, opc_d, fn_q, fn_d;
    logic [4:0] rd_q, rd_d, dl1_q, dl1_d, dl2_q, dl2_d;
    logic [31:0] a_q, a_d, b_q, b_d, res_q, res_d, alu;
    logic [15:0] retired_q, retired_d;
    logic accept, valid, unused_shamt;
    assign unused_shamt = ^instr[10:6];
    always_comb begin
        accept = state_q == IDLE && instr_valid;
        valid = opc_q == 6'd0 && (fn_q == 6'h20 || fn_q == 6'h22 || fn_q == 6'h24 ||
                                  fn_q == 6'h25 || fn_q == 6'h2A);
        case (state_q)
            IDLE:    state_d = instr_valid ? READ : IDLE;
            READ:    state_d = EXEC;
            EXEC:    state_d = WRITE;
            default: state_d = IDLE;
        endcase
        opc_d = accept ? instr[31:26] : opc_q;
        fn_d = accept ? instr[5:0] : fn_q;
        rd_d = accept ? instr[15:11] : rd_q;
        // Read addresses are loaded at accept so they are already valid during READ.
        dl1_d = accept ? instr[25:21] : dl1_q;
        dl2_d = accept ? instr[20:16] : dl2_q;
        a_d = state_q == READ ? op1 : a_q;
        b_d = state_q == READ ? op2 : b_q;
        alu = fn_q == 6'h20 ? a_q + b_q :
              fn_q == 6'h22 ? a_q - b_q :
              fn_q == 6'h24 ? a_q & b_q :
              fn_q == 6'h25 ? a_q | b_q :
              {31'd0, $signed(a_q) < $signed(b_q)};
        res_d = state_q == EXEC ? alu : res_q;
        retired_d = state_q == WRITE ? retired_q + 16'd1 : retired_q;
        instr_ready = state_q == IDLE;
        done = state_q == WRITE;
        err = done && !valid;
        we = done && valid && rd_q != 5'd0;
        DL1 = dl1_q;
        DL2 = dl2_q;
        DE = rd_q;
        Dato = res_q;
        retired = retired_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            opc_q <= '0;
            fn_q <= '0;
            rd_q <= '0;
            dl1_q <= '0;
            dl2_q <= '0;
            a_q <= '0;
            b_q <= '0;
            res_q <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            opc_q <= opc_d;
            fn_q <= fn_d;
            rd_q <= rd_d;
            dl1_q <= dl1_d;
            dl2_q <= dl2_d;
            a_q <= a_d;
            b_q <= b_d;
            res_q <= res_d;
            retired_q <= retired_d;
        end
    end
endmodule

// File: tb/tb_br_sequencer.sv
// tb_br_sequencer: table vectors, reset/back-to-back/wrap sequences and random
// instructions checked against an arithmetic reference model.
module tb_br_sequencer;
    logic clk = 1'b0;
    logic rst, instr_valid, instr_ready, we, done, err;
    logic [31:0] instr, op1, op2, Dato;
    logic [4:0] DL1, DL2, DE;
    logic [15:0] retired;
    logic [31:0] rf [32];
    int checks = 0;
    int failures = 0;
    logic [15:0] exp_ret;
    logic we_seen;
    typedef struct {logic [31:0] ins, v1, v2, dato; logic we, err;} vec_t;
    typedef struct {logic we, err; logic [4:0] de; logic [31:0] dato;} exp_t;
    vec_t vt [14];

    always #5 clk = ~clk;
    assign op1 = rf[DL1];
    assign op2 = rf[DL2];
    always @(negedge clk) if (we) we_seen = 1'b1;

    br_sequencer dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .DL1(DL1), .DL2(DL2), .op1(op1), .op2(op2),
        .we(we), .DE(DE), .Dato(Dato), .done(done), .err(err), .retired(retired)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [5:0] f);
        return {op, rs, rt, rd, 5'd0, f};
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        exp_t m;
        int sa, sb;
        sa = a;
        sb = b;
        m.err = 1'b0;
        m.dato = 32'd0;
        if (ins[31:26] != 6'd0) m.err = 1'b1;
        else case (ins[5:0])
            6'h20: m.dato = a + b;
            6'h22: m.dato = a - b;
            6'h24: m.dato = a & b;
            6'h25: m.dato = a | b;
            6'h2A: m.dato = (sa < sb) ? 32'd1 : 32'd0;
            default: m.err = 1'b1;
        endcase
        m.de = ins[15:11];
        m.we = !m.err && m.de != 5'd0;
        return m;
    endfunction

    task automatic run(input string name, input logic [31:0] ins, input exp_t e);
        int lat;
        for (int n = 0; n < 20 && !instr_ready; n++) @(negedge clk);
        chk({name, " ready"}, 32'(instr_ready), 32'd1);
        instr = ins;
        instr_valid = 1'b1;
        @(negedge clk);
        chk({name, " busy"}, 32'(instr_ready), 32'd0);
        chk({name, " DL1"}, 32'(DL1), 32'(ins[25:21]));
        chk({name, " DL2"}, 32'(DL2), 32'(ins[20:16]));
        lat = 1;
        while (!done && lat < 10) begin
            if (we) chk({name, " early_we"}, 32'(we), 32'd0);
            instr = $urandom;
            instr_valid = 1'b1;
            @(negedge clk);
            lat++;
        end
        instr_valid = 1'b0;
        chk({name, " latency"}, 32'(lat), 32'd3);
        chk({name, " err"}, 32'(err), 32'(e.err));
        chk({name, " we"}, 32'(we), 32'(e.we));
        chk({name, " DE"}, 32'(DE), 32'(e.de));
        if (!e.err) chk({name, " Dato"}, Dato, e.dato);
        @(negedge clk);
        exp_ret = exp_ret + 16'd1;
        chk({name, " retired"}, 32'(retired), 32'(exp_ret));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int accepts, dones, last;
        logic [4:0] rs, rt, rd;
        logic [5:0] fsel [6];
        vt[0]  = '{mk(0, 1, 2, 3, 6'h20), 32'd5, 32'd7, 32'd12, 1'b1, 1'b0};
        vt[1]  = '{mk(0, 2, 1, 4, 6'h2A), 32'hFFFFFFFF, 32'd3, 32'd1, 1'b1, 1'b0};
        vt[2]  = '{mk(0, 1, 2, 5, 6'h22), 32'd3, 32'hFFFFFFFF, 32'd4, 1'b1, 1'b0};
        vt[3]  = '{mk(0, 1, 2, 6, 6'h24), 32'hF0F0FF00, 32'h0FF0F0F0, 32'h00F0F000, 1'b1, 1'b0};
        vt[4]  = '{mk(0, 1, 2, 7, 6'h25), 32'hF0F0FF00, 32'h0FF0F0F0, 32'hFFF0FFF0, 1'b1, 1'b0};
        vt[5]  = '{mk(0, 1, 2, 8, 6'h3F), 32'd5, 32'd7, 32'd0, 1'b0, 1'b1};
        vt[6]  = '{mk(6'h08, 1, 2, 9, 6'h20), 32'd5, 32'd7, 32'd0, 1'b0, 1'b1};
        vt[7]  = '{mk(0, 1, 2, 0, 6'h20), 32'd5, 32'd7, 32'd12, 1'b0, 1'b0};
        vt[8]  = '{mk(0, 1, 2, 10, 6'h2A), 32'd7, 32'hFFFFFFFF, 32'd0, 1'b1, 1'b0};
        vt[9]  = '{mk(0, 9, 10, 9, 6'h22), 32'd10, 32'd3, 32'd7, 1'b1, 1'b0};
        vt[10] = '{mk(0, 1, 2, 11, 6'h20), 32'hFFFFFFFF, 32'd2, 32'd1, 1'b1, 1'b0};
        vt[11] = '{mk(0, 3, 4, 12, 6'h22), 32'd0, 32'd1, 32'hFFFFFFFF, 1'b1, 1'b0};
        vt[12] = '{mk(0, 3, 4, 13, 6'h2A), 32'd5, 32'd5, 32'd0, 1'b1, 1'b0};
        vt[13] = '{mk(0, 3, 4, 14, 6'h2A), 32'h80000000, 32'h7FFFFFFF, 32'd1, 1'b1, 1'b0};
        fsel = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        rf[1] = 32'd5;
        rf[2] = 32'd7;
        rst = 1'b1;
        instr_valid = 1'b0;
        instr = 32'd0;
        exp_ret = 16'd0;
        we_seen = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst ready", 32'(instr_ready), 32'd1);
        chk("rst flags", {29'd0, we, done, err}, 32'd0);
        chk("rst addrs", {17'd0, DL1, DL2, DE}, 32'd0);
        chk("rst Dato", Dato, 32'd0);
        chk("rst retired", 32'(retired), 32'd0);
        instr = mk(0, 1, 2, 3, 6'h20);
        instr_valid = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        chk("accept after rst", 32'(instr_ready), 32'd0);
        chk("accept after rst DL1", 32'(DL1), 32'd1);
        instr_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midexec rst ready", 32'(instr_ready), 32'd1);
        chk("midexec rst flags", {29'd0, we, done, err}, 32'd0);
        chk("midexec rst addrs", {17'd0, DL1, DL2, DE}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("midexec no write", 32'(we_seen), 32'd0);
        chk("midexec retired", 32'(retired), 32'd0);

        foreach (vt[i]) begin
            rf[vt[i].ins[25:21]] = vt[i].v1;
            rf[vt[i].ins[20:16]] = vt[i].v2;
            e = '{vt[i].we, vt[i].err, vt[i].ins[15:11], vt[i].dato};
            run($sformatf("vec%0d", i), vt[i].ins, e);
        end

        instr = mk(0, 1, 2, 3, 6'h20);
        instr_valid = 1'b1;
        accepts = 0;
        dones = 0;
        last = -1;
        for (int c = 0; c < 24; c++) begin
            if (done) dones++;
            if (instr_ready) begin
                if (last >= 0) chk("b2b gap", 32'(c - last), 32'd4);
                last = c;
                accepts++;
            end
            @(negedge clk);
        end
        instr_valid = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("b2b accepts", 32'(accepts), 32'd6);
        chk("b2b dones", 32'(dones), 32'(accepts));
        exp_ret = exp_ret + 16'(accepts);
        chk("b2b retired", 32'(retired), 32'(exp_ret));

        for (int i = 0; i < 40; i++) begin
            rs = 5'($urandom_range(1, 31));
            rt = 5'($urandom_range(1, 31));
            rd = 5'($urandom_range(0, 31));
            rf[rs] = $urandom;
            rf[rt] = ($urandom_range(0, 3) == 0) ? rf[rs] : $urandom;
            fsel[5] = 6'($urandom);
            instr = mk(($urandom_range(0, 7) == 0) ? 6'($urandom_range(1, 63)) : 6'd0,
                       rs, rt, rd, fsel[$urandom_range(0, 5)]);
            e = model(instr, rf[rs], rf[rt]);
            run($sformatf("rand%0d", i), instr, e);
        end

        force dut.retired_q = 16'hFFFF;
        #1 release dut.retired_q;
        #1 chk("preset retired", 32'(retired), 32'hFFFF);
        exp_ret = 16'hFFFF;
        rf[1] = 32'd5;
        rf[2] = 32'd7;
        run("wrap", mk(0, 1, 2, 3, 6'h20), model(mk(0, 1, 2, 3, 6'h20), 32'd5, 32'd7));
        chk("wrap zero", 32'(retired), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
